// File: rtl/compressor.sv
// Line compressor: classifies each 32-bit word of a 256-bit line by the number of
// significant leading bytes, emits a 2-bit size code per word and packs the kept
// bytes MSB-aligned into a zero-filled 256-bit output. One register stage.
module compressor (
    input  logic         clk,
    input  logic         reset,
    input  logic         wrtEn,
    input  logic [255:0] dataIn,
    input  logic [255:0] cprDataIn,
    input  logic [15:0]  tagIn,
    output logic [255:0] dataOut,
    output logic [15:0]  tagOut
);

    logic [15:0]  tag_next;
    logic [255:0] data_next;
    logic [5:0]   comp_len;
    logic [5:0]   acc;
    logic [31:0]  word;
    logic [31:0]  kept;
    logic [1:0]   code;
    logic [2:0]   nbytes;

    // Debug inputs and the compressed length have no functional sink.
    logic unused_dbg;
    assign unused_dbg = ^{cprDataIn, tagIn, comp_len};

    // Classify words 7..0 and OR each kept (MSB-aligned) word in at its running byte offset.
    always_comb begin
        tag_next  = '0;
        data_next = '0;
        acc       = '0;
        word      = '0;
        kept      = '0;
        code      = 2'b00;
        nbytes    = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            word = dataIn[32*k +: 32];
            if (word == '0) begin
                code   = 2'b00;
                kept   = '0;
                nbytes = 3'd0;
            end else if (word[23:0] == '0) begin
                code   = 2'b01;
                kept   = {word[31:24], 24'h0};
                nbytes = 3'd1;
            end else if (word[15:0] == '0) begin
                code   = 2'b10;
                kept   = {word[31:16], 16'h0};
                nbytes = 3'd2;
            end else begin
                code   = 2'b11;
                kept   = word;
                nbytes = 3'd4;
            end
            tag_next[2*k +: 2] = code;
            // Bytes beyond the kept ones are zero in 'kept', so a plain OR packs cleanly.
            data_next = data_next | ({kept, 224'h0} >> {acc, 3'b000});
            acc       = acc + {3'b000, nbytes};
        end
        comp_len = acc;
    end

    // Output register: reset wins over capture; hold when not enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            dataOut <= '0;
            tagOut  <= '0;
        end else if (wrtEn) begin
            dataOut <= data_next;
            tagOut  <= tag_next;
        end
    end

endmodule

// File: tb/tb_compressor.sv
// Directed bench for compressor: table of lines with hand-packed expectations,
// plus short sequences for hold, reset priority and debug-input independence.
module tb_compressor;

    logic         clk = 1'b0;
    logic         reset;
    logic         wrtEn;
    logic [255:0] dataIn;
    logic [255:0] cprDataIn;
    logic [15:0]  tagIn;
    logic [255:0] dataOut;
    logic [15:0]  tagOut;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    compressor dut (
        .clk       (clk),
        .reset     (reset),
        .wrtEn     (wrtEn),
        .dataIn    (dataIn),
        .cprDataIn (cprDataIn),
        .tagIn     (tagIn),
        .dataOut   (dataOut),
        .tagOut    (tagOut)
    );

    typedef struct {
        string        name;
        logic [255:0] din;
        logic [15:0]  exp_tag;
        logic [255:0] exp_data;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive on the falling edge, let one rising edge pass, sample 1 time unit later.
    task automatic step(input logic rst, input logic en, input logic [255:0] din);
        @(negedge clk);
        reset  = rst;
        wrtEn  = en;
        dataIn = din;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{"tp1",
            256'h12000000_00000000_34000000_56780000_9ABCDEF1_23000000_45670000_89ABCDEF,
            16'h46DB, {120'h123456789ABCDEF123456789ABCDEF, 136'h0}};
        vecs[1] = '{"tp2",
            256'h12340000_56780000_9ABC0000_DE000000_F1000000_23450000_67000000_00000000,
            16'hA964, {88'h123456789ABCDEF1234567, 168'h0}};
        vecs[2] = '{"tp3",
            256'h12340000_00000000_00000000_00000000_00000000_00000000_56780000_9ABCDEF1,
            16'h800B, {64'h123456789ABCDEF1, 192'h0}};
        vecs[3] = '{"all_zero", 256'h0, 16'h0000, 256'h0};
        vecs[4] = '{"full",
            256'h12345678_9ABCDEF1_23456789_ABCDEF12_3456789A_BCDEF123_456789AB_CDEF1234,
            16'hFFFF,
            256'h12345678_9ABCDEF1_23456789_ABCDEF12_3456789A_BCDEF123_456789AB_CDEF1234};
        vecs[5] = '{"low_byte_w7", {32'h00000012, 224'h0}, 16'hC000, {32'h00000012, 224'h0}};
        vecs[6] = '{"w0_only", {224'h0, 32'hAABBCCDD}, 16'h0003, {32'hAABBCCDD, 224'h0}};
        vecs[7] = '{"w0_one_byte", {224'h0, 32'h77000000}, 16'h0001, {8'h77, 248'h0}};

        reset     = 1'b1;
        wrtEn     = 1'b0;
        dataIn    = '0;
        cprDataIn = '0;
        tagIn     = '0;

        // Reset state.
        step(1'b1, 1'b0, 256'h0);
        check("reset_data", dataOut, 256'h0);
        check("reset_tag", {240'h0, tagOut}, 256'h0);

        // Table, applied back-to-back.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, vecs[i].din);
            check({vecs[i].name, "_tag"}, {240'h0, tagOut}, {240'h0, vecs[i].exp_tag});
            check({vecs[i].name, "_data"}, dataOut, vecs[i].exp_data);
        end

        // Hold: load tp1, then disable and change dataIn.
        step(1'b0, 1'b1, vecs[0].din);
        step(1'b0, 1'b0, vecs[4].din);
        check("hold_tag", {240'h0, tagOut}, {240'h0, 16'h46DB});
        check("hold_data", dataOut, vecs[0].exp_data);
        step(1'b0, 1'b0, vecs[1].din);
        check("hold2_data", dataOut, vecs[0].exp_data);

        // Debug inputs toggled while holding: no change.
        @(negedge clk);
        cprDataIn = {8{32'hDEADBEEF}};
        tagIn     = 16'hBEEF;
        @(posedge clk);
        #1;
        check("dbg_hold_tag", {240'h0, tagOut}, {240'h0, 16'h46DB});
        check("dbg_hold_data", dataOut, vecs[0].exp_data);

        // Debug inputs toggled while capturing: result depends on dataIn only.
        @(negedge clk);
        cprDataIn = {8{32'h01234567}};
        tagIn     = 16'h5A5A;
        step(1'b0, 1'b1, vecs[2].din);
        check("dbg_cap_tag", {240'h0, tagOut}, {240'h0, 16'h800B});
        check("dbg_cap_data", dataOut, vecs[2].exp_data);

        // Reset has priority over wrtEn and discards the capture.
        step(1'b1, 1'b1, vecs[4].din);
        check("rst_pri_tag", {240'h0, tagOut}, 256'h0);
        check("rst_pri_data", dataOut, 256'h0);

        // Capture resumes right after reset drops.
        step(1'b0, 1'b1, vecs[1].din);
        check("post_rst_tag", {240'h0, tagOut}, {240'h0, 16'hA964});
        check("post_rst_data", dataOut, vecs[1].exp_data);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/compressor.md
Name: compressor

Overview:
- Single-cycle, registered line compressor for a 256-bit cache line.
- Splits the line into eight 32-bit words and classifies each word by how many leading (most-significant) bytes are significant.
- Emits a 16-bit tag (2 bits per word) and the significant bytes packed contiguously, MSB-aligned, in a 256-bit output.
- Sits between the cache-line source and the compressed-storage write path. It is the counterpart of the decompressor, which uses the same tag encoding.

Parameters:
- None. Widths are fixed: 256-bit line, 8 words of 32 bits, 16-bit tag.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- wrtEn  input  1  capture enable; when 1, dataIn is compressed into the output registers on the clock edge
- dataIn  input  256  uncompressed line; word k = dataIn[32k+31:32k], word 7 is the MSB word
- cprDataIn  input  256  debug-only input, no functional effect on outputs
- tagIn  input  16  debug-only input, no functional effect on outputs
- dataOut  output  256  packed compressed bytes, MSB-aligned, zero-filled below
- tagOut  output  16  per-word size codes; tagOut[2k+1:2k] belongs to word k

Behaviour:
- Word classification, per 32-bit word w:
  - w == 0 -> code 00, 0 bytes kept.
  - else if w[23:0] == 0 -> code 01, 1 byte kept: w[31:24].
  - else if w[15:0] == 0 -> code 10, 2 bytes kept: w[31:16].
  - else -> code 11, all 4 bytes kept.
  - Nonzero low-order bytes always force code 11. Example: 0x00000012 -> 11.
- Packing:
  - Kept bytes are concatenated in order word 7 first, down to word 0.
  - Within a word, kept bytes are emitted MSB first.
  - The first kept byte goes to dataOut[255:248], the next to [247:240], and so on.
  - All bytes after the last kept byte are 0.
- Compressed length: L = sum of kept bytes, range 0..32.
  - L is computed internally and is not a port.
  - When L = 32, dataOut equals dataIn.
- Timing:
  - Outputs are registered, latency 1 cycle.
  - At a rising edge with wrtEn=1 and reset=0, tagOut and dataOut take the result computed from that cycle's dataIn.
  - When wrtEn=0, outputs hold their previous values.
- Reset:
  - reset=1 at a rising edge clears dataOut to 0 and tagOut to 0.
  - Reset has priority over wrtEn.
  - Reset asserted mid-stream discards the pending capture for that edge.
- X handling: none required. An undriven dataIn may propagate X to the outputs.
- No handshake or backpressure: one line is accepted per enabled cycle, and back-to-back lines are allowed.
- Datapath is combinational (classify, prefix-sum the byte counts, shift/OR into position) feeding a single register stage.

Test Plan:
- dataIn=1200_0000_0000_0000_3400_0000_5678_0000_9ABC_DEF1_2300_0000_4567_0000_89AB_CDEF, wrtEn=1 -> next cycle:
  - tagOut=0100011011011011 (0x46DB).
  - dataOut=123456789ABCDEF123456789ABCDEF followed by 17 zero bytes (L=15).
- dataIn=1234_0000_5678_0000_9ABC_0000_DE00_0000_F100_0000_2345_0000_6700_0000_0000_0000 -> next cycle:
  - tagOut=1010100101100100 (0xA964).
  - dataOut=123456789ABCDEF1234567 followed by 21 zero bytes (L=11).
- dataIn=1234_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_0000_5678_0000_9ABC_DEF1 -> next cycle:
  - tagOut=1000000000001011 (0x800B).
  - dataOut=123456789ABCDEF1 followed by 24 zero bytes (L=8).
- Edge cases:
  - dataIn=all zero -> tagOut=0x0000, dataOut=0 (L=0).
  - dataIn=1234_5678_9ABC_DEF1_2345_6789_ABCD_EF12_3456_789A_BCDE_F123_4567_89AB_CDEF_1234 -> tagOut=0xFFFF, dataOut=dataIn (L=32).
  - Word 0x00000012 in word 7 with all other words zero -> tagOut=0xC000, dataOut[255:224]=0x00000012, rest 0.
- Control:
  - Load a nonzero result, then set wrtEn=0 and change dataIn -> outputs hold.
  - Assert reset with wrtEn=1 -> dataOut=0 and tagOut=0 at that edge.
  - Toggling cprDataIn/tagIn at any time -> no output change.
